sr_bank_arbiter: RTL and testbench
==================================

# sr_bank_arbiter

Round-robin arbiter and sequencer that shares a bank of SR flip-flops among several requesters. Each requester asks to set or reset one bit of the bank. The block serializes those requests, drives exactly one S or R strobe per transaction, and keeps a shadow copy of the bank state. It sits between requesting logic and the SR flip-flop bank. It guarantees the illegal S=R=1 condition never reaches any flip-flop.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR flip-flops in the bank (1..32)
- IDXW, $clog2(NBITS) (minimum 1), width of one bit index
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; held high until ack
- req_set  in  NREQ  per-requester command: 1 = set bit, 0 = reset bit
- req_idx  in  NREQ*IDXW  packed bit indices; requester k uses [k*IDXW +: IDXW]
- gnt  out  NREQ  one-hot grant, high in DRIVE and DONE
- ack  out  NREQ  one-hot completion pulse, high in DONE only
- s_bus  out  NBITS  one-hot set strobe to the bank
- r_bus  out  NBITS  one-hot reset strobe to the bank
- q  out  NBITS  shadow bank state
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states and transitions:
  - IDLE: if req is nonzero, pick the winner by round-robin. Latch its command and index, set gnt, go to DRIVE. If req is zero, stay in IDLE.
  - DRIVE: s_bus[idx] (set) or r_bus[idx] (reset) is high for exactly this cycle. Go to DONE.
  - DONE: ack[winner] is high. q[idx] updates at the end of this cycle: 1 on set, 0 on reset. The round-robin pointer becomes the winner. Go to IDLE.
- Round-robin:
  - Search begins at pointer+1, modulo NREQ.
  - After reset the pointer is NREQ-1, so requester 0 has first priority.
- Command and index are captured in IDLE. Changes to req_set or req_idx after the grant are ignored.
- If the winner drops req during DRIVE or DONE, the transaction still completes and ack still pulses.
- Strobe rules:
  - s_bus and r_bus are never both nonzero in the same cycle.
  - Each bus is at most one-hot.
  - Both buses are zero outside DRIVE.
- Out-of-range index (idx >= NBITS): no strobe is driven, q is unchanged, and ack is still given.
- Two requesters targeting the same bit with opposite commands are serialized in round-robin order. The later transaction determines the final q.
- A requester must sample ack and drop req by the next rising edge. A req still high in the following IDLE cycle is treated as a new request.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE and the pointer to NREQ-1.
  - gnt, ack, s_bus, r_bus and busy go to 0.
  - q goes to all zeros, matching the flip-flop bank's reset Q=0.
- Reset mid-transaction:
  - Strobes and gnt drop immediately.
  - No ack is issued and q is not updated.
  - Operation resumes in IDLE on the first clk edge after rst_n rises.
- Transaction timeline, with req seen high at edge E0 (state IDLE):
  - DRIVE is the cycle after E0; gnt and the strobe are high.
  - DONE is the next cycle; gnt and ack are high.
  - q is updated at the edge ending DONE.
- Request-to-ack latency is 2 cycles. Each transaction occupies 3 cycles including IDLE, so peak throughput is 1 transaction per 3 cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
- Reset values: hold rst_n low with random inputs -> q=0, gnt=0, ack=0, s_bus=0, r_bus=0, busy=0.
- Single set: req=0001, req_set[0]=1, idx0=5 -> in DRIVE s_bus=0x20 and r_bus=0, then ack=0001. After DONE q=0x20. The following reset of idx 5 returns q to 0x00.
- Round-robin fairness:
  - Setup: NREQ=4, req=1111 held continuously, each requester setting a distinct bit (0..3).
  - Required: grants in order 0,1,2,3,0.
  - Required: no requester receives two grants before every other active requester has received one.
  - Required: q=0x0F after the first four transactions.
- Same-bit conflict: requester 1 sets bit 2 while requester 2 resets bit 2, both raised at once -> requester 1 served first, then requester 2. s_bus and r_bus never overlap, and the final q[2]=0.
- Reset mid-DRIVE: assert rst_n low during the DRIVE cycle -> strobes drop immediately, no ack, q=0. After release, a pending req is served starting from requester 0 priority.
- Out-of-range index: with NBITS=6, request idx=7 -> no strobe, ack pulses 2 cycles after the request, q unchanged.

Source files
------------

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter
// Round-robin arbiter/sequencer sharing a bank of SR flip-flops among NREQ
// requesters. Each transaction runs IDLE -> DRIVE -> DONE. DRIVE issues one
// S or R strobe and DONE issues the ack. A shadow copy of the bank is kept
// in q_o. Because the strobes are decoded from a single latched command,
// S and R can never both be high.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_i      per-requester request, held until ack
//   req_set_i  per-requester command (1 = set, 0 = reset)
//   req_idx_i  packed bit indices, requester k at [k*IDXW +: IDXW]
//   gnt_o      one-hot grant (DRIVE and DONE)
//   ack_o      one-hot completion pulse (DONE)
//   s_bus_o    one-hot set strobe (DRIVE, set command)
//   r_bus_o    one-hot reset strobe (DRIVE, reset command)
//   q_o        shadow bank state
//   busy_o     high whenever not IDLE
module sr_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBITS = 8,
  parameter int unsigned IDXW  = (NBITS > 1) ? $clog2(NBITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_set_i,
  input  logic [NREQ*IDXW-1:0] req_idx_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      ack_o,
  output logic [NBITS-1:0]     s_bus_o,
  output logic [NBITS-1:0]     r_bus_o,
  output logic [NBITS-1:0]     q_o,
  output logic                 busy_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  win_q, win_d;
  logic             set_q, set_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [NBITS-1:0] q_q, q_d;

  logic [PtrW-1:0]  pick;
  logic             pick_vld;
  logic             sel_set;
  logic [IDXW-1:0]  sel_idx;

  // Round-robin pick: first scan requesters above the pointer, then wrap
  // around to those at or below it. Command and index of the winner are
  // selected alongside so they can be latched in IDLE.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sel_set  = 1'b0;
    sel_idx  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_vld && (j > 32'(ptr_q)) && req_i[j]) begin
        pick_vld = 1'b1;
        pick     = PtrW'(j);
        sel_set  = req_set_i[j];
        sel_idx  = req_idx_i[j*IDXW +: IDXW];
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_vld && (j <= 32'(ptr_q)) && req_i[j]) begin
        pick_vld = 1'b1;
        pick     = PtrW'(j);
        sel_set  = req_set_i[j];
        sel_idx  = req_idx_i[j*IDXW +: IDXW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    set_d   = set_q;
    idx_d   = idx_q;
    q_d     = q_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          win_d   = pick;
          set_d   = sel_set;
          idx_d   = sel_idx;
          state_d = StDrive;
        end
      end
      StDrive: state_d = StDone;
      StDone: begin
        // Out-of-range indices match no bit, leaving the shadow unchanged.
        for (int unsigned b = 0; b < NBITS; b++) begin
          if (32'(idx_q) == b) q_d[b] = set_q;
        end
        ptr_d   = win_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= PtrW'(NREQ - 1);
      win_q   <= '0;
      set_q   <= 1'b0;
      idx_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      set_q   <= set_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    gnt_o   = '0;
    ack_o   = '0;
    s_bus_o = '0;
    r_bus_o = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      gnt_o[k] = ((state_q == StDrive) || (state_q == StDone)) && (32'(win_q) == k);
      ack_o[k] = (state_q == StDone) && (32'(win_q) == k);
    end
    for (int unsigned b = 0; b < NBITS; b++) begin
      s_bus_o[b] = (state_q == StDrive) && set_q && (32'(idx_q) == b);
      r_bus_o[b] = (state_q == StDrive) && !set_q && (32'(idx_q) == b);
    end
  end

  assign busy_o = (state_q != StIdle);
  assign q_o    = q_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Self-checking bench for sr_bank_arbiter (NREQ=4, NBITS=6 so that indices
// 6 and 7 are out of range). It uses a vector table, hand-written corner
// sequences, and a randomized phase checked against a transaction-level model.
module tb_sr_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NBITS = 6;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req, req_set;
  logic [NREQ*IDXW-1:0] req_idx;
  logic [NREQ-1:0]      gnt, ack;
  logic [NBITS-1:0]     s_bus, r_bus, q;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  sr_bank_arbiter #(
    .NREQ (NREQ),
    .NBITS(NBITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (req),
    .req_set_i(req_set),
    .req_idx_i(req_idx),
    .gnt_o    (gnt),
    .ack_o    (ack),
    .s_bus_o  (s_bus),
    .r_bus_o  (r_bus),
    .q_o      (q),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe safety is monitored on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("s_r_overlap", 32'((|s_bus) && (|r_bus)), 32'd0);
      check("s_onehot0", 32'($onehot0(s_bus)), 32'd1);
      check("r_onehot0", 32'($onehot0(r_bus)), 32'd1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    req     = 4'($urandom);
    req_set = 4'($urandom);
    req_idx = 12'($urandom);
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_s", 32'(s_bus), 32'd0);
    check("rst_r", 32'(r_bus), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req     = '0;
    req_set = '0;
    req_idx = '0;
    rst_n   = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  set;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [5:0]  s;
    logic [5:0]  r;
    logic [5:0]  q;
  } vec_t;

  vec_t vecs[8];

  // Transaction-level model state for the random phase.
  logic [3:0] pend;
  logic [3:0] cset;
  int         cidx[4];
  int         last;
  logic [5:0] q_m;

  task automatic drive_model();
    req     = pend;
    req_set = cset;
    for (int k = 0; k < NREQ; k++) req_idx[k*IDXW +: IDXW] = 3'(cidx[k]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // req, set, idx, exp gnt, exp s, exp r, exp q after DONE
    vecs[0] = '{4'b0001, 4'b0001, 12'h005, 4'b0001, 6'h20, 6'h00, 6'h20};
    vecs[1] = '{4'b0001, 4'b0000, 12'h005, 4'b0001, 6'h00, 6'h20, 6'h00};
    vecs[2] = '{4'b0100, 4'b0100, 12'h0C0, 4'b0100, 6'h08, 6'h00, 6'h08};
    vecs[3] = '{4'b1000, 4'b1000, 12'hE00, 4'b1000, 6'h00, 6'h00, 6'h08};
    vecs[4] = '{4'b0010, 4'b0000, 12'h018, 4'b0010, 6'h00, 6'h08, 6'h00};
    vecs[5] = '{4'b0110, 4'b0110, 12'h040, 4'b0100, 6'h02, 6'h00, 6'h02};
    vecs[6] = '{4'b0101, 4'b0101, 12'h084, 4'b0001, 6'h10, 6'h00, 6'h12};
    vecs[7] = '{4'b1111, 4'b0010, 12'h200, 4'b0010, 6'h01, 6'h00, 6'h13};

    rst_n   = 1'b1;
    req     = '0;
    req_set = '0;
    req_idx = '0;
    do_reset();

    // Table: one transaction per vector, commands scrambled after grant.
    for (int i = 0; i < 8; i++) begin
      req     = vecs[i].req;
      req_set = vecs[i].set;
      req_idx = vecs[i].idx;
      tick();
      check($sformatf("v%0d_drive_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_drive_s", i), 32'(s_bus), 32'(vecs[i].s));
      check($sformatf("v%0d_drive_r", i), 32'(r_bus), 32'(vecs[i].r));
      check($sformatf("v%0d_drive_busy", i), 32'(busy), 32'd1);
      check($sformatf("v%0d_drive_ack", i), 32'(ack), 32'd0);
      req_set = ~vecs[i].set;
      req_idx = ~vecs[i].idx;
      tick();
      check($sformatf("v%0d_done_ack", i), 32'(ack), 32'(vecs[i].gnt));
      check($sformatf("v%0d_done_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_done_strobe", i), 32'(s_bus | r_bus), 32'd0);
      req = '0;
      tick();
      check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // Fairness: all four requesters held high, requester k sets bit k.
    do_reset();
    req     = 4'b1111;
    req_set = 4'b1111;
    req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("rr%0d_gnt", t), 32'(gnt), 32'(1) << (t % 4));
      check($sformatf("rr%0d_s", t), 32'(s_bus), 32'(1) << (t % 4));
      tick();
      check($sformatf("rr%0d_ack", t), 32'(ack), 32'(1) << (t % 4));
      if (t == 4) req = '0;
      tick();
      if (t == 3) check("rr_q_after4", 32'(q), 32'h0F);
    end

    // Same-bit conflict: r1 sets bit 2, r2 resets bit 2.
    do_reset();
    req     = 4'b0110;
    req_set = 4'b0010;
    req_idx = 12'h090;
    tick();
    check("cf1_gnt", 32'(gnt), 32'b0010);
    check("cf1_s", 32'(s_bus), 32'h04);
    check("cf1_r", 32'(r_bus), 32'h00);
    tick();
    check("cf1_ack", 32'(ack), 32'b0010);
    req = 4'b0100;
    tick();
    check("cf1_q", 32'(q), 32'h04);
    tick();
    check("cf2_gnt", 32'(gnt), 32'b0100);
    check("cf2_s", 32'(s_bus), 32'h00);
    check("cf2_r", 32'(r_bus), 32'h04);
    tick();
    check("cf2_ack", 32'(ack), 32'b0100);
    req = '0;
    tick();
    check("cf_final_q", 32'(q), 32'h00);

    // Reset in the middle of DRIVE.
    do_reset();
    req     = 4'b0001;
    req_set = 4'b0001;
    req_idx = 12'h003;
    tick();
    check("md_drive_s", 32'(s_bus), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("md_rst_s", 32'(s_bus), 32'd0);
    check("md_rst_r", 32'(r_bus), 32'd0);
    check("md_rst_gnt", 32'(gnt), 32'd0);
    check("md_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("md_rst_ack", 32'(ack), 32'd0);
    check("md_rst_q", 32'(q), 32'd0);
    req     = 4'b1001;
    req_set = 4'b1001;
    req_idx = 12'h203;
    rst_n   = 1'b1;
    tick();
    check("md_after_gnt", 32'(gnt), 32'b0001);
    check("md_after_s", 32'(s_bus), 32'h08);
    tick();
    check("md_after_ack", 32'(ack), 32'b0001);
    req = '0;
    tick();
    check("md_after_q", 32'(q), 32'h08);

    // Randomized phase against a transaction-level model.
    do_reset();
    pend = '0;
    cset = '0;
    for (int k = 0; k < NREQ; k++) cidx[k] = 0;
    last = NREQ - 1;
    q_m  = '0;
    for (int t = 0; t < 150; t++) begin
      int w;
      logic [5:0] es, er;
      for (int k = 0; k < NREQ; k++) begin
        if (!pend[k] && ($urandom_range(0, 2) == 0)) begin
          pend[k] = 1'b1;
          cset[k] = 1'($urandom_range(0, 1));
          cidx[k] = $urandom_range(0, 7);
        end
      end
      drive_model();
      if (pend == '0) begin
        tick();
        check("rnd_idle_busy", 32'(busy), 32'd0);
        check("rnd_idle_gnt", 32'(gnt), 32'd0);
        continue;
      end
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        int c;
        c = (last + i) % NREQ;
        if (w < 0 && pend[c]) w = c;
      end
      es = (cset[w] && cidx[w] < NBITS) ? 6'(1 << cidx[w]) : 6'd0;
      er = (!cset[w] && cidx[w] < NBITS) ? 6'(1 << cidx[w]) : 6'd0;
      tick();
      check("rnd_gnt", 32'(gnt), 32'(1) << w);
      check("rnd_s", 32'(s_bus), 32'(es));
      check("rnd_r", 32'(r_bus), 32'(er));
      check("rnd_busy", 32'(busy), 32'd1);
      req_set[w] = ~cset[w];
      req_idx[w*IDXW +: IDXW] = 3'($urandom);
      tick();
      check("rnd_ack", 32'(ack), 32'(1) << w);
      check("rnd_done_strobe", 32'(s_bus | r_bus), 32'd0);
      if (cidx[w] < NBITS) q_m[cidx[w]] = cset[w];
      last    = w;
      pend[w] = 1'b0;
      drive_model();
      tick();
      check("rnd_q", 32'(q), 32'(q_m));
      check("rnd_idle_busy2", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
